not_equal_array: RTL and testbench
==================================

NOT_EQUAL_ARRAY -- requirements
Module: not_equal_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent a/b comparison channels.
REQ-002 Parameter GAMMA_CYCLE_WIDTH, default 16: gamma-cycle window length in aclk cycles.
REQ-003 Parameter PULSE_WIDTH, default 8: output pulse length in aclk cycles, at least 1.
REQ-004 The block SHALL use a single clock and an asynchronous, active-high reset.
REQ-005 Port aclk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port grst, input, 1: asynchronous, active-high reset that also starts a new gamma cycle.
REQ-007 Port a, input, N_CH: per-channel primary race signal; a 0->1 transition marks arrival.
REQ-008 Port b, input, N_CH: per-channel reference race signal; a 0->1 transition marks arrival.
REQ-009 Port mode, input, N_CH: per channel, 0 = NEQ, 1 = LT; mode SHALL be held static within a gamma cycle.
REQ-010 Port y, output, N_CH: per-channel registered output pulse.
REQ-011 Port done, output, N_CH: per-channel flag, set once the channel's decision for the gamma cycle is final.
REQ-012 Port window_open, output, 1: high while arrivals are accepted.

Function
REQ-013 Time counter t: width clog2(GAMMA_CYCLE_WIDTH+1); increments by 1 each aclk; saturates at GAMMA_CYCLE_WIDTH.
REQ-014 window_open = (t < GAMMA_CYCLE_WIDTH); arrivals are sampled only on aclk edges where window_open is 1.
REQ-015 Arrival detection per signal: rise = signal & ~prev, with prev registered every cycle; a level already high at window start does not count as an arrival.
REQ-016 Per-channel FSM states: ARMED, FIRE, DONE; b_seen flag is cleared in ARMED.
REQ-017 ARMED, b rises and a does not: set b_seen; stay in ARMED.
REQ-018 ARMED, a and b rise in the same cycle: go to DONE, no pulse (equal times), in both modes.
REQ-019 ARMED, a rises with b_seen=1: NEQ -> FIRE; LT -> DONE, no pulse.
REQ-020 ARMED, a rises with b_seen=0: FIRE in both modes.
REQ-021 FIRE: y[i]=1 for exactly PULSE_WIDTH consecutive cycles, starting the cycle after the sampling edge (latency 1), then DONE.
REQ-022 At most one pulse per channel per gamma cycle; further a/b edges are ignored in FIRE and DONE.
REQ-023 A pulse in progress when the window closes SHALL run to its full length.
REQ-024 Channels left in ARMED when the window closes go to DONE, no pulse (a = infinity).
REQ-025 done[i]=1 in DONE only; in FIRE, done[i] rises on the cycle after the last y cycle.
REQ-026 Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

Reset
REQ-027 While grst=1: t=0, all prev=0, b_seen=0, all FSMs ARMED, y=0, done=0, window_open=1 (combinational from t).
REQ-028 grst asserted mid-pulse SHALL clear y immediately (asynchronous); no residual pulse after release.
REQ-029 The first sampling edge after grst falls SHALL see t=0.

Configuration
REQ-030 Macro NOT_EQUAL_ARRAY_TIMESTAMP_EN.
REQ-031 Defined: extra output y_time, N_CH x clog2(GAMMA_CYCLE_WIDTH+1), holds t captured at the firing sampling edge.
REQ-032 Defined: y_time is valid from the first y cycle and held until grst; it resets to all-ones and stays all-ones for non-firing channels.
REQ-033 Not defined: y_time port and its registers are absent; all other behaviour is identical.

Verification
REQ-034 N_CH=4, GAMMA=16, PULSE=8, mode=0: ch0 a rises at t=3, b never -> y[0] high t=4..11, done[0] at t=12, y_time[0]=3.
REQ-035 mode=0, ch1 a and b rise at t=5 -> y[1] never high; done[1]=1 from t=6.
REQ-036 ch2 b at t=2, a at t=6: mode=0 -> y pulses t=7..14; mode=1 -> no pulse, done at t=7.
REQ-037 ch3 a rises at t=14 -> pulse t=15..22, extending past the window close at t=16; a rising at t=16 -> no pulse, done.
REQ-038 grst asserted at t=6 during a ch0 pulse that started at t=4 -> y[0]=0 at once; next gamma cycle ch0 is ARMED and fires again on a new edge.
REQ-039 a held high across grst release, with no new edge -> no pulse; channel reaches DONE at window close.

Source files
------------

// File: rtl/not_equal_array.sv
// rtl/not_equal_array.sv - per-channel race-logic NEQ/LT comparator with gamma-cycle window (optional timestamp: NOT_EQUAL_ARRAY_TIMESTAMP_EN)
module not_equal_array #(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                 aclk,
  input  logic                 grst,
  input  logic [N_CH-1:0]      a,
  input  logic [N_CH-1:0]      b,
  input  logic [N_CH-1:0]      mode,
  output logic [N_CH-1:0]      y,
  output logic [N_CH-1:0]      done,
  output logic                 window_open
`ifdef NOT_EQUAL_ARRAY_TIMESTAMP_EN
  ,
  output logic [N_CH-1:0][$clog2(GAMMA_CYCLE_WIDTH+1)-1:0] y_time
`endif
);

  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH + 1);
  localparam int CW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [TW-1:0] T_MAX    = TW'(GAMMA_CYCLE_WIDTH);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {ARMED, FIRE, DONE} state_t;

  logic [TW-1:0]   t_q;
  logic [N_CH-1:0] prev_a_q;
  logic [N_CH-1:0] prev_b_q;
  logic            prev_valid_q;
  logic [N_CH-1:0] rise_a;
  logic [N_CH-1:0] rise_b;

  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];
  logic [N_CH-1:0] b_seen_q;
  logic [N_CH-1:0] b_seen_d;
  logic [N_CH-1:0] y_d;

  assign window_open = (t_q < T_MAX);

  // The history registers hold zero through reset, so the first edge after
  // release has no trustworthy previous level; prev_valid_q masks it so a
  // level already high at window start is never taken as an arrival.
  assign rise_a = a & ~prev_a_q & {N_CH{prev_valid_q}};
  assign rise_b = b & ~prev_b_q & {N_CH{prev_valid_q}};

  // Gamma-cycle time counter, saturating at the window length.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      t_q <= '0;
    end else if (t_q != T_MAX) begin
      t_q <= t_q + T_ONE;
    end
  end

  // Input history for rising-edge detection, sampled every cycle.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      prev_a_q     <= '0;
      prev_b_q     <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_a_q     <= a;
      prev_b_q     <= b;
      prev_valid_q <= 1'b1;
    end
  end

  // Per-channel decision FSMs: next state, pulse counter and b_seen.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      b_seen_d[i] = b_seen_q[i];
      case (state_q[i])
        ARMED: begin
          if (!window_open) begin
            state_d[i] = DONE;
          end else if (rise_a[i] && rise_b[i]) begin
            state_d[i] = DONE;
          end else if (rise_a[i]) begin
            if (b_seen_q[i] && mode[i]) begin
              state_d[i] = DONE;
            end else begin
              state_d[i] = FIRE;
              cnt_d[i]   = CNT_LOAD;
            end
          end else if (rise_b[i]) begin
            b_seen_d[i] = 1'b1;
          end
        end
        FIRE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = DONE;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        DONE: begin
          state_d[i] = DONE;
        end
        default: begin
          state_d[i] = ARMED;
        end
      endcase
      y_d[i] = (state_d[i] == FIRE);
    end
  end

  // FSM state, counter and registered pulse output.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ARMED;
        cnt_q[i]   <= '0;
      end
      b_seen_q <= '0;
      y        <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      b_seen_q <= b_seen_d;
      y        <= y_d;
    end
  end

  // done is a pure decode of the DONE state register.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      done[i] = (state_q[i] == DONE);
    end
  end

`ifdef NOT_EQUAL_ARRAY_TIMESTAMP_EN
  logic [N_CH-1:0] fire_now;

  // A channel fires exactly on the edge that moves it from ARMED to FIRE.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fire_now[i] = (state_q[i] == ARMED) && (state_d[i] == FIRE);
    end
  end

  // Capture the firing time; all-ones marks a channel that never fired.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      y_time <= '1;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (fire_now[i]) begin
          y_time[i] <= t_q;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_not_equal_array.sv
// tb/tb_not_equal_array.sv - directed self-checking bench for not_equal_array
module tb_not_equal_array;

  localparam int N_CH  = 4;
  localparam int GW    = 16;
  localparam int PW    = 8;
  localparam int TW    = $clog2(GW + 1);
  localparam int T_ONES = (1 << TW) - 1;

  logic            aclk = 1'b0;
  logic            grst;
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] b;
  logic [N_CH-1:0] mode;
  logic [N_CH-1:0] y;
  logic [N_CH-1:0] done;
  logic            window_open;
`ifdef NOT_EQUAL_ARRAY_TIMESTAMP_EN
  logic [N_CH-1:0][TW-1:0] y_time;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  not_equal_array #(
    .N_CH(N_CH),
    .GAMMA_CYCLE_WIDTH(GW),
    .PULSE_WIDTH(PW)
  ) dut (
    .aclk(aclk),
    .grst(grst),
    .a(a),
    .b(b),
    .mode(mode),
    .y(y),
    .done(done),
    .window_open(window_open)
`ifdef NOT_EQUAL_ARRAY_TIMESTAMP_EN
    ,
    .y_time(y_time)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Scenario 0: NEQ mix; 1: LT mix; 2: NEQ pulse cut by reset; 3: after mid-pulse reset.
  function automatic logic [3:0] stim_a(input int s, input int c);
    case (s)
      0:       return {c >= 14, c >= 6, c >= 5, c >= 3};
      1:       return {c >= 16, c >= 6, c >= 5, c >= 3};
      2:       return {1'b0, 1'b0, 1'b0, c >= 3};
      default: return {1'b0, 1'b0, 1'b1, (c == 0) || (c >= 4)};
    endcase
  endfunction

  function automatic logic [3:0] stim_b(input int s, input int c);
    case (s)
      0, 1:    return {1'b0, c >= 2, c >= 5, 1'b0};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] exp_y(input int s, input int c);
    case (s)
      0:       return {in_rng(c, 15, 22), in_rng(c, 7, 14), 1'b0, in_rng(c, 4, 11)};
      1, 2:    return {1'b0, 1'b0, 1'b0, in_rng(c, 4, 11)};
      default: return {1'b0, 1'b0, 1'b0, in_rng(c, 5, 12)};
    endcase
  endfunction

  function automatic logic [3:0] exp_done(input int s, input int c);
    case (s)
      0:       return {c >= 23, c >= 15, c >= 6, c >= 12};
      1:       return {c >= 17, c >= 7, c >= 6, c >= 12};
      2:       return {c >= 17, c >= 17, c >= 17, c >= 12};
      default: return {c >= 17, c >= 17, c >= 17, c >= 13};
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, " y"}, 32'(y), 32'd0);
    check_val({tag, " done"}, 32'(done), 32'd0);
    check_val({tag, " window_open"}, 32'(window_open), 32'd1);
`ifdef NOT_EQUAL_ARRAY_TIMESTAMP_EN
    for (int i = 0; i < N_CH; i++) begin
      check_val($sformatf("%s y_time%0d", tag, i), 32'(y_time[i]), T_ONES);
    end
`endif
  endtask

  task automatic do_reset(input bit wait_edge, input string tag);
    if (wait_edge) @(negedge aclk);
    grst = 1'b1;
    #1;
    check_reset_state(tag);
    repeat (2) @(negedge aclk);
    grst = 1'b0;
  endtask

  // Iteration c checks the outputs seen while t=c, then drives the inputs
  // sampled at the edge where t=c.
  task automatic run_gamma(input int s, input int last_c);
    for (int c = 0; c <= last_c; c++) begin
      check_val($sformatf("s%0d y t=%0d", s, c), 32'(y), 32'(exp_y(s, c)));
      check_val($sformatf("s%0d done t=%0d", s, c), 32'(done), 32'(exp_done(s, c)));
      check_val($sformatf("s%0d window_open t=%0d", s, c), 32'(window_open), 32'(c < GW));
      if (c == last_c) break;
      a = stim_a(s, c);
      b = stim_b(s, c);
      @(negedge aclk);
    end
  endtask

  task automatic check_times(input string tag, input int t0, input int t1, input int t2, input int t3);
`ifdef NOT_EQUAL_ARRAY_TIMESTAMP_EN
    check_val({tag, " y_time0"}, 32'(y_time[0]), t0);
    check_val({tag, " y_time1"}, 32'(y_time[1]), t1);
    check_val({tag, " y_time2"}, 32'(y_time[2]), t2);
    check_val({tag, " y_time3"}, 32'(y_time[3]), t3);
`else
    if (t0 + t1 + t2 + t3 < 0) $display("unexpected timestamp arguments %s", tag);
`endif
  endtask

  initial begin
    grst = 1'b1;
    a    = '0;
    b    = '0;
    mode = 4'b0000;
    repeat (2) @(negedge aclk);
    do_reset(1'b1, "init");
    run_gamma(0, 24);
    check_times("neq", 3, T_ONES, 6, 14);

    a    = '0;
    b    = '0;
    mode = 4'b1111;
    do_reset(1'b1, "lt");
    run_gamma(1, 24);
    check_times("lt", 3, T_ONES, T_ONES, T_ONES);

    a    = '0;
    b    = '0;
    mode = 4'b0000;
    do_reset(1'b1, "pre");
    run_gamma(2, 6);
    a = 4'b0011;
    do_reset(1'b0, "midpulse");
    run_gamma(3, 24);
    check_times("again", 4, T_ONES, T_ONES, T_ONES);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
